// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl: triggered waveform capture into a two-bank sample RAM.
// Arms on a rising zero crossing of the decimated sample stream and fills the
// write bank with 2^ADDR_W samples. The read bank is swapped on the next vsync
// rising edge, so the display only ever sees a complete frame.
// Optional build macro: TRIG_TIMEOUT_EN forces a trigger after TIMEOUT accepted
// samples in WAIT_TRIG, so silence or DC still refreshes the display.
module wave_capture_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DECIM   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_sample,
  input  logic [15:0]       sample,
  input  logic              vsync,
  input  logic              freeze,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_bank,
  output logic              busy
);

  localparam int unsigned DecW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DecW-1:0] DecLast = DecW'(DECIM - 1);
  localparam logic [ADDR_W-1:0] IdxLast = '1;

  typedef enum logic [1:0] {StWaitTrig, StCapture, StDone} state_e;

  state_e            state_q, state_d;
  logic [DecW-1:0]   dec_cnt_q, dec_cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  // Only the sign of the previous accepted sample matters for the trigger.
  logic              prev_neg_q, prev_neg_d;
  logic              vsync_q;
  logic              wr_bank_q, wr_bank_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rd_bank_q, rd_bank_d;
  logic              busy_q, busy_d;

  logic accept;
  logic vsync_rise;
  logic real_trig;
  logic force_trig;
  logic [7:0] sample_ob;

  // The low byte is below display resolution.
  logic unused_sample_lo;
  assign unused_sample_lo = ^sample[7:0];

  assign accept     = new_sample && (dec_cnt_q == DecLast);
  assign vsync_rise = vsync && !vsync_q;
  assign real_trig  = accept && prev_neg_q && !sample[15];
  assign sample_ob  = {~sample[15], sample[14:8]};

`ifdef TRIG_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  // Once TIMEOUT samples have gone by untriggered, the next accepted one fires.
  assign force_trig = accept && (to_cnt_q == ToMax);

  // Timeout counter: counts untriggered accepted samples in WAIT_TRIG.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != StWaitTrig) begin
      to_cnt_d = '0;
    end else if (accept && (to_cnt_q != ToMax) && !real_trig) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign force_trig = 1'b0;
`endif

  // Next-state: decimation, trigger detection, capture sequencing, bank swap.
  always_comb begin
    state_d    = state_q;
    dec_cnt_d  = dec_cnt_q;
    idx_d      = idx_q;
    prev_neg_d = prev_neg_q;
    wr_bank_d  = wr_bank_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_bank_d  = rd_bank_q;

    if (new_sample) begin
      dec_cnt_d = accept ? '0 : dec_cnt_q + DecW'(1);
    end
    if (accept) begin
      prev_neg_d = sample[15];
    end

    unique case (state_q)
      StWaitTrig: begin
        if (!freeze && (real_trig || force_trig)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {wr_bank_q, {ADDR_W{1'b0}}};
          wr_data_d = sample_ob;
          idx_d     = ADDR_W'(1);
          state_d   = StCapture;
        end
      end
      StCapture: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {wr_bank_q, idx_q};
          wr_data_d = sample_ob;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      StDone: begin
        // Samples arriving here only update prev_neg; they never trigger.
        if (vsync_rise && !freeze) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          state_d   = StWaitTrig;
        end
      end
      default: state_d = StWaitTrig;
    endcase

    busy_d = (state_d == StCapture);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StWaitTrig;
      dec_cnt_q  <= '0;
      idx_q      <= '0;
      prev_neg_q <= 1'b0;
      vsync_q    <= 1'b0;
      wr_bank_q  <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_bank_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dec_cnt_q  <= dec_cnt_d;
      idx_q      <= idx_d;
      prev_neg_q <= prev_neg_d;
      vsync_q    <= vsync;
      wr_bank_q  <= wr_bank_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_bank_q  <= rd_bank_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_bank = rd_bank_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl (ADDR_W=3; DECIM=1 and DECIM=4 copies).
module tb_wave_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_sample = 1'b0;
  logic [15:0] sample = '0;
  logic        vsync = 1'b0;
  logic        freeze = 1'b0;

  logic       wr_en, rd_bank, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en4, rd_bank4, busy4;
  logic [3:0] wr_addr4;
  logic [7:0] wr_data4;

  // Outputs observed one cycle after the last stimulus pulse.
  logic       o_en, o_rd, o_busy, o4_en;
  logic [3:0] o_addr, o4_addr;
  logic [7:0] o_data, o4_data;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wave_capture_ctrl #(.ADDR_W(3), .DECIM(1), .TIMEOUT(16)) u_dut (
    .clk(clk), .reset(reset), .new_sample(new_sample), .sample(sample),
    .vsync(vsync), .freeze(freeze), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_bank(rd_bank), .busy(busy)
  );

  wave_capture_ctrl #(.ADDR_W(3), .DECIM(4), .TIMEOUT(16)) u_dut4 (
    .clk(clk), .reset(reset), .new_sample(new_sample), .sample(sample),
    .vsync(vsync), .freeze(freeze), .wr_en(wr_en4), .wr_addr(wr_addr4),
    .wr_data(wr_data4), .rd_bank(rd_bank4), .busy(busy4)
  );

  task automatic observe();
    o_en = wr_en; o_addr = wr_addr; o_data = wr_data; o_rd = rd_bank; o_busy = busy;
    o4_en = wr_en4; o4_addr = wr_addr4; o4_data = wr_data4;
  endtask

  // One new_sample pulse, then capture outputs at the following negedge.
  task automatic send(input logic [15:0] s);
    @(negedge clk); sample = s; new_sample = 1'b1;
    @(negedge clk); new_sample = 1'b0;
    observe();
  endtask

  task automatic vsync_pulse();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    observe();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, rd_bank, busy} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got en=%b addr=%h data=%h rd=%b busy=%b want all 0",
               wr_en, wr_addr, wr_data, rd_bank, busy);
    end
    n_cmp++;
    if ({wr_en4, wr_addr4, wr_data4, rd_bank4, busy4} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_d4 got en=%b addr=%h data=%h want all 0",
               wr_en4, wr_addr4, wr_data4);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_first_trigger();
    send(16'hFFFB);  // -5
    n_cmp++;
    if (o_en !== 1'b0) begin
      n_fail++; $display("FAIL t1_no_write_on_neg got en=%b want 0", o_en);
    end
    send(16'h0003);
    n_cmp++;
    if ({o_en, o_addr, o_data, o_busy} !== {1'b1, 4'b1000, 8'h80, 1'b1}) begin
      n_fail++;
      $display("FAIL t1_trigger_write got en=%b addr=%h data=%h busy=%b want 1 8 80 1",
               o_en, o_addr, o_data, o_busy);
    end
    @(negedge clk);
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL t1_wr_en_one_cycle got %b want 0", wr_en);
    end
  endtask

  task automatic test_fill_and_swap();
    for (int i = 1; i < 8; i++) begin
      send(16'(i * 256));
      n_cmp++;
      if ({o_en, o_addr, o_data} !== {1'b1, 4'(8 + i), 8'(8'h80 + i)}) begin
        n_fail++;
        $display("FAIL t2_fill_%0d got en=%b addr=%h data=%h want 1 %h %h", i, o_en,
                 o_addr, o_data, 4'(8 + i), 8'(8'h80 + i));
      end
    end
    n_cmp++;
    if ({o_busy, o_rd} !== 2'b00) begin
      n_fail++; $display("FAIL t2_done_state got busy=%b rd=%b want 0 0", o_busy, o_rd);
    end
    vsync_pulse();
    n_cmp++;
    if (o_rd !== 1'b1) begin
      n_fail++; $display("FAIL t2_swap got rd=%b want 1", o_rd);
    end
    send(16'hFFFB);
    for (int i = 0; i < 8; i++) begin
      send(16'h0003);
      n_cmp++;
      if ({o_en, o_addr} !== {1'b1, 4'(i)}) begin
        n_fail++;
        $display("FAIL t2_bank0_%0d got en=%b addr=%h want 1 %h", i, o_en, o_addr, 4'(i));
      end
    end
  endtask

  task automatic test_vsync_mid_capture();
    vsync_pulse();
    n_cmp++;
    if (o_rd !== 1'b0) begin
      n_fail++; $display("FAIL t3_swap_back got rd=%b want 0", o_rd);
    end
    send(16'hFFFB);
    for (int i = 0; i < 4; i++) send(16'h0010);
    n_cmp++;
    if ({o_en, o_addr, o_busy} !== {1'b1, 4'd11, 1'b1}) begin
      n_fail++;
      $display("FAIL t3_four_writes got en=%b addr=%h busy=%b want 1 b 1", o_en, o_addr, o_busy);
    end
    vsync_pulse();
    n_cmp++;
    if ({o_rd, o_en} !== 2'b00) begin
      n_fail++; $display("FAIL t3_vsync_ignored got rd=%b en=%b want 0 0", o_rd, o_en);
    end
    for (int i = 0; i < 4; i++) send(16'h0010);
    n_cmp++;
    if ({o_en, o_addr, o_busy, o_rd} !== {1'b1, 4'd15, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL t3_complete got en=%b addr=%h busy=%b rd=%b want 1 f 0 0",
               o_en, o_addr, o_busy, o_rd);
    end
    vsync_pulse();
    n_cmp++;
    if (o_rd !== 1'b1) begin
      n_fail++; $display("FAIL t3_next_vsync_swaps got rd=%b want 1", o_rd);
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    send(16'hFFFB);
    send(16'h0003);
    n_cmp++;
    if (o_en !== 1'b0) begin
      n_fail++; $display("FAIL t5_freeze_blocks_trigger got en=%b want 0", o_en);
    end
    freeze = 1'b0;
    send(16'hFFFB);
    for (int i = 0; i < 8; i++) send(16'h0003);
    n_cmp++;
    if ({o_en, o_addr, o_busy} !== {1'b1, 4'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL t5_capture got en=%b addr=%h busy=%b want 1 7 0", o_en, o_addr, o_busy);
    end
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vsync_pulse();
      n_cmp++;
      if ({o_rd, o_en} !== 2'b10) begin
        n_fail++; $display("FAIL t5_frozen_vsync_%0d got rd=%b en=%b want 1 0", i, o_rd, o_en);
      end
    end
    send(16'hFFFB);
    send(16'h0003);
    n_cmp++;
    if (o_en !== 1'b0) begin
      n_fail++; $display("FAIL t5_done_no_write got en=%b want 0", o_en);
    end
    freeze = 1'b0;
    vsync_pulse();
    n_cmp++;
    if (o_rd !== 1'b0) begin
      n_fail++; $display("FAIL t5_unfreeze_swap got rd=%b want 0", o_rd);
    end
  endtask

  task automatic test_back_to_back();
    send(16'hFFFB);
    for (int i = 0; i < 8; i++) send(16'h0003);
    n_cmp++;
    if ({o_en, o_addr} !== {1'b1, 4'd15}) begin
      n_fail++; $display("FAIL t7_capture got en=%b addr=%h want 1 f", o_en, o_addr);
    end
    send(16'hFFFB);
    // Accepted crossing sample coincides with the swapping vsync edge.
    @(negedge clk); vsync = 1'b1; sample = 16'h0003; new_sample = 1'b1;
    @(negedge clk); vsync = 1'b0; new_sample = 1'b0;
    observe();
    n_cmp++;
    if ({o_en, o_rd} !== 2'b01) begin
      n_fail++; $display("FAIL t7_simul_swap got en=%b rd=%b want 0 1", o_en, o_rd);
    end
    send(16'h0004);
    n_cmp++;
    if (o_en !== 1'b0) begin
      n_fail++; $display("FAIL t7_no_carried_trigger got en=%b want 0", o_en);
    end
    send(16'hFFFB);
    send(16'h0003);
    n_cmp++;
    if ({o_en, o_addr} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL t7_retrigger got en=%b addr=%h want 1 0", o_en, o_addr);
    end
  endtask

  task automatic test_decim();
    logic [15:0] pat [8];
    pat = '{16'd100, -16'sd100, 16'd100, -16'sd100, 16'd100, -16'sd100, -16'sd100, 16'd100};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(pat[i]);
      n_cmp++;
      if (o4_en !== (i == 7)) begin
        n_fail++; $display("FAIL t4_pulse_%0d got en=%b want %b", i + 1, o4_en, i == 7);
      end
    end
    n_cmp++;
    if ({o4_addr, o4_data} !== {4'b1000, 8'h80}) begin
      n_fail++; $display("FAIL t4_write got addr=%h data=%h want 8 80", o4_addr, o4_data);
    end
  endtask

  task automatic test_reset_mid_capture();
    do_reset();
    send(16'hFFFB);
    for (int i = 0; i < 3; i++) send(16'h4000);
    n_cmp++;
    if ({o_en, o_addr, o_data, o_busy} !== {1'b1, 4'd10, 8'hC0, 1'b1}) begin
      n_fail++;
      $display("FAIL t6_pre_reset got en=%b addr=%h data=%h busy=%b want 1 a c0 1",
               o_en, o_addr, o_data, o_busy);
    end
    @(negedge clk); #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, rd_bank, busy} !== 15'd0) begin
      n_fail++;
      $display("FAIL t6_async_reset got en=%b addr=%h data=%h rd=%b busy=%b want all 0",
               wr_en, wr_addr, wr_data, rd_bank, busy);
    end
    @(negedge clk); reset = 1'b0;
    send(16'hFFFB);
    send(16'h0003);
    n_cmp++;
    if ({o_en, o_addr, o_rd} !== {1'b1, 4'b1000, 1'b0}) begin
      n_fail++;
      $display("FAIL t6_restart got en=%b addr=%h rd=%b want 1 8 0", o_en, o_addr, o_rd);
    end
  endtask

`ifdef TRIG_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      send(16'h0700);
      n_cmp++;
      if (o_en !== (i == 17)) begin
        n_fail++; $display("FAIL t8_timeout_%0d got en=%b want %b", i, o_en, i == 17);
      end
    end
    n_cmp++;
    if (o_addr !== 4'b1000) begin
      n_fail++; $display("FAIL t8_forced_addr got %h want 8", o_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_trigger();
    test_fill_and_swap();
    test_vsync_mid_capture();
    test_freeze();
    test_back_to_back();
    test_decim();
    test_reset_mid_capture();
`ifdef TRIG_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
